// File: rtl/conv_channel_model.sv
// conv_channel_model: binary channel placed between the convolutional encoder
// and the Viterbi decoder. Each valid symbol is registered (latency 1) and, at
// a rate set by RATE_N, a pseudo-random error mask from a 32-bit Galois LFSR
// is XORed into it. Saturating statistics count symbols, corrupted symbols and
// flipped bits. Injection is limited to the first WINDOW symbols after reset
// or clear.
//
// Optional feature: define CHAN_BURST_EN to enable burst injection (the BURST
// state, latched burst mask and burst counter). Without it burst_mode_i is
// ignored and every trigger corrupts exactly one symbol.
//
// Handshake: valid_i qualifies sym_i for one cycle; valid_o follows valid_i
// one cycle later. There is no ready/backpressure, so every valid symbol is
// accepted and produced exactly once.

module conv_channel_model #(
  parameter int          SYM_W      = 2,
  parameter int          RATE_N     = 3,
  parameter int          WINDOW     = 256,
  parameter int          BURST_LOG2 = 2,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             burst_mode_i,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] err_mask_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] err_sym_ct_o,
  output logic [CNT_W-1:0] err_bit_ct_o,
  output logic             window_done_o,
  output logic [1:0]       dbg_state_o
);

  localparam logic [31:0] TAPS      = 32'h80200003;
  localparam logic [31:0] WIN_U     = 32'(WINDOW);
  // Low RATE_N bits of the LFSR must all be one to trigger; RATE_N=0 always triggers.
  localparam logic [31:0] RATE_MASK = (RATE_N == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - RATE_N));

  typedef enum logic [1:0] {
    S_CLEAN = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_lfsr;
  logic             r_valid;
  logic [SYM_W-1:0] r_sym;
  logic [SYM_W-1:0] r_mask;
  logic [CNT_W-1:0] r_sym_ct;
  logic [CNT_W-1:0] r_err_sym_ct;
  logic [CNT_W-1:0] r_err_bit_ct;
  logic             r_window_done;

`ifdef CHAN_BURST_EN
  localparam int            BC_W       = (BURST_LOG2 < 1) ? 1 : BURST_LOG2;
  localparam logic [BC_W-1:0] BURST_INIT = BC_W'((1 << BURST_LOG2) - 1);

  logic [BC_W-1:0]  r_burst_cnt;
  logic [SYM_W-1:0] r_burst_mask;
  logic [BC_W-1:0]  w_burst_cnt_nxt;
  logic [SYM_W-1:0] w_burst_mask_nxt;
`else
  logic w_unused_burst_mode;
  assign w_unused_burst_mode = burst_mode_i;
`endif

  logic [31:0]      w_lfsr_nxt;
  logic             w_in_window;
  logic             w_trig;
  logic [SYM_W-1:0] w_rand_mask;
  logic [SYM_W-1:0] w_mask;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_sym_ct_nxt;
  logic [CNT_W-1:0] w_err_sym_ct_nxt;
  logic [CNT_W:0]   w_pop;
  logic [CNT_W:0]   w_bit_sum;
  logic [CNT_W-1:0] w_err_bit_ct_nxt;
  logic             w_done_nxt;

  // Galois LFSR step, trigger condition and the candidate random mask.
  always_comb begin
    w_lfsr_nxt  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'd0);
    w_in_window = (32'(r_sym_ct) < WIN_U);
    w_trig      = valid_i & enable_i & w_in_window & ((r_lfsr & RATE_MASK) == RATE_MASK);
    w_rand_mask = '0;
    for (int i = 0; i < SYM_W; i++) begin
      w_rand_mask[i] = r_lfsr[RATE_N + i];
    end
    // A trigger must flip at least one bit.
    if (w_rand_mask == '0) begin
      w_rand_mask = SYM_W'(1);
    end
  end

  // Mask selection and FSM next-state for the current valid symbol.
  always_comb begin
    w_mask      = '0;
    w_state_nxt = r_state;
`ifdef CHAN_BURST_EN
    w_burst_cnt_nxt  = r_burst_cnt;
    w_burst_mask_nxt = r_burst_mask;
`endif
    case (r_state)
      S_CLEAN: begin
        if (w_trig) begin
          w_mask = w_rand_mask;
`ifdef CHAN_BURST_EN
          if (burst_mode_i && (BURST_LOG2 > 0)) begin
            w_burst_mask_nxt = w_rand_mask;
            w_burst_cnt_nxt  = BURST_INIT;
            w_state_nxt      = S_BURST;
          end
`endif
        end
      end
`ifdef CHAN_BURST_EN
      S_BURST: begin
        if (valid_i) begin
          if (!enable_i) begin
            // Disabling injection aborts the burst; this symbol passes clean.
            w_state_nxt = S_CLEAN;
          end else begin
            w_mask          = r_burst_mask;
            w_burst_cnt_nxt = r_burst_cnt - BC_W'(1);
            if (r_burst_cnt == BC_W'(1)) begin
              w_state_nxt = S_CLEAN;
            end
          end
        end
      end
`endif
      default: begin
        w_mask = '0;
      end
    endcase
  end

  // Saturating statistics for the symbol being output.
  always_comb begin
    w_sym_ct_nxt     = (r_sym_ct == '1) ? r_sym_ct : r_sym_ct + CNT_W'(1);
    w_err_sym_ct_nxt = ((w_mask != '0) && (r_err_sym_ct != '1)) ? r_err_sym_ct + CNT_W'(1)
                                                                 : r_err_sym_ct;
    w_pop = '0;
    for (int i = 0; i < SYM_W; i++) begin
      w_pop = w_pop + {{CNT_W{1'b0}}, w_mask[i]};
    end
    w_bit_sum        = {1'b0, r_err_bit_ct} + w_pop;
    w_err_bit_ct_nxt = w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
    w_done_nxt       = (32'(w_sym_ct_nxt) >= WIN_U);
  end

  // Single state register: FSM, LFSR, output registers and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_CLEAN;
      r_lfsr        <= LFSR_SEED;
      r_valid       <= 1'b0;
      r_sym         <= '0;
      r_mask        <= '0;
      r_sym_ct      <= '0;
      r_err_sym_ct  <= '0;
      r_err_bit_ct  <= '0;
      r_window_done <= 1'b0;
`ifdef CHAN_BURST_EN
      r_burst_cnt   <= '0;
      r_burst_mask  <= '0;
`endif
    end else if (clear_i) begin
      r_state       <= S_CLEAN;
      r_lfsr        <= LFSR_SEED;
      r_sym_ct      <= '0;
      r_err_sym_ct  <= '0;
      r_err_bit_ct  <= '0;
      r_window_done <= 1'b0;
      r_valid       <= valid_i;
      // A symbol arriving with clear goes out clean and uncounted.
      if (valid_i) begin
        r_sym  <= sym_i;
        r_mask <= '0;
      end
`ifdef CHAN_BURST_EN
      r_burst_cnt   <= '0;
      r_burst_mask  <= '0;
`endif
    end else if (valid_i) begin
      r_valid       <= 1'b1;
      r_sym         <= sym_i ^ w_mask;
      r_mask        <= w_mask;
      r_lfsr        <= w_lfsr_nxt;
      r_sym_ct      <= w_sym_ct_nxt;
      r_err_sym_ct  <= w_err_sym_ct_nxt;
      r_err_bit_ct  <= w_err_bit_ct_nxt;
      r_window_done <= w_done_nxt;
      r_state       <= w_done_nxt ? S_DONE : w_state_nxt;
`ifdef CHAN_BURST_EN
      r_burst_cnt   <= w_burst_cnt_nxt;
      r_burst_mask  <= w_burst_mask_nxt;
`endif
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o       = r_valid;
  assign sym_o         = r_sym;
  assign err_mask_o    = r_mask;
  assign sym_ct_o      = r_sym_ct;
  assign err_sym_ct_o  = r_err_sym_ct;
  assign err_bit_ct_o  = r_err_bit_ct;
  assign window_done_o = r_window_done;
  assign dbg_state_o   = r_state;

endmodule
